// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus.
// Groups the data/control inputs and the match outputs of seq_detect_param.
//   in        : serial data bit, qualified by valid
//   valid     : qualifies in; cycles with valid=0 are ignored
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   load      : load pat_in as the new pattern and flush the history
//   pat_in    : new pattern, oldest bit in [PAT_W-1]
//   out       : combinational (Mealy) match flag
//   out_reg   : out delayed by one clock
//   match_cnt : saturating match count since reset
// master drives the inputs (stimulus side), slave is the detector.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in;
  logic             valid;
  logic             overlap;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             out;
  logic             out_reg;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in, valid, overlap, load, pat_in,
    input  out, out_reg, match_cnt
  );

  modport slave (
    input  in, valid, overlap, load, pat_in,
    output out, out_reg, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parameterised serial sequence detector.
// Compares the last PAT_W valid bits (history plus the bit currently on
// bus.in) against a loadable pattern and flags a match combinationally in the
// cycle the final pattern bit arrives. Supports overlapping and
// non-overlapping detection, a registered copy of the flag, and a saturating
// match counter.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset; overrides load and valid
//   bus : seq_detect_param_if.slave (in, valid, overlap, load, pat_in ->
//         out, out_reg, match_cnt)
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_param_if.slave bus
);

  localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              out_reg_q, out_reg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              match;
  logic [PAT_W-1:0]  window;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Candidate window: stored history followed by the bit on the wire now.
  assign window = {hist_q, bus.in};

  // A match needs a full history (fill saturated) so that bits from before a
  // flush can never contribute.
  assign match = bus.valid & ~bus.load & ~rst &
                 (fill_q == FILL_MAX) & (window == pat_q);

  always_comb begin
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    out_reg_d = match;
    if (rst) begin
      pat_d  = PATTERN;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.valid) begin
      hist_d = window[PAT_W-2:0];
      if (match) begin
        // Overlap keeps the history usable; non-overlap demands PAT_W new bits.
        fill_d = bus.overlap ? fill_q : '0;
        cnt_d  = sat_inc(cnt_q);
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    pat_q     <= pat_d;
    hist_q    <= hist_d;
    fill_q    <= fill_d;
    cnt_q     <= cnt_d;
    out_reg_q <= out_reg_d;
  end

  assign bus.out       = match;
  assign bus.out_reg   = out_reg_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) bus  ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       valid;
    logic       in;
    logic       ovl;
    logic [3:0] pat_in;
    logic       exp_out;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic ld, logic v, logic i, logic o,
                              logic [3:0] p, logic eo, logic [7:0] ec);
    vec_t t;
    t.rst = r; t.load = ld; t.valid = v; t.in = i; t.ovl = o;
    t.pat_in = p; t.exp_out = eo; t.exp_cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic prev_out;
    int   pulses;
    logic [1:0] sat_exp[5];
    logic [3:0] grp;

    bus.in = 0; bus.valid = 0; bus.overlap = 0; bus.load = 0; bus.pat_in = '0;
    bus2.in = 0; bus2.valid = 0; bus2.overlap = 0; bus2.load = 0; bus2.pat_in = '0;
    rst = 1; rst2 = 1;

    // Reset held with load/valid active: out must stay low.
    @(negedge clk);
    bus.valid = 1; bus.in = 1; bus.load = 1;
    #1 check("rst_out", 32'(bus.out), 32'd0);
    @(negedge clk);
    bus.valid = 0; bus.load = 0; bus.in = 0; rst = 0;
    #1;
    check("rst_out_reg", 32'(bus.out_reg), 32'd0);
    check("rst_cnt",     32'(bus.match_cnt), 32'd0);

    // Overlap stream 1011011: matches on bits 4 and 7.
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,1,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,1,1));
    vecs.push_back(mk(1,1,1,1,1,4'h0,0,2));
    // Non-overlap: overlap is low only on the match cycle, so only bit 4 hits.
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,0,4'h0,1,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,1));
    vecs.push_back(mk(1,0,0,0,1,4'h0,0,1));
    // Gaps with in toggling while valid is low.
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,0,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,0,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,0,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,1,0));
    vecs.push_back(mk(0,0,0,1,1,4'h0,0,1));
    // Reload 0110, stream 0110110: matches on bits 4 and 7.
    vecs.push_back(mk(0,1,1,1,1,4'b0110,0,1));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,1));
    vecs.push_back(mk(0,0,1,0,1,4'h0,1,1));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,2));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,2));
    vecs.push_back(mk(0,0,1,0,1,4'h0,1,2));
    // Old pattern 1011 no longer matches.
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,3));
    // Load on a cycle whose window would match 0110: suppressed, back to 1011.
    vecs.push_back(mk(0,1,1,0,1,4'b1011,0,3));
    // Partial 101, reset, then 1 1011: only the last group matches.
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,3));
    vecs.push_back(mk(1,0,1,1,1,4'h0,0,3));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,0,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,0,0));
    vecs.push_back(mk(0,0,1,1,1,4'h0,1,0));
    vecs.push_back(mk(0,0,0,1,1,4'h0,0,1));

    prev_out = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      bus.load    = vecs[i].load;
      bus.valid   = vecs[i].valid;
      bus.in      = vecs[i].in;
      bus.overlap = vecs[i].ovl;
      bus.pat_in  = vecs[i].pat_in;
      #1;
      check($sformatf("v%0d_out", i),     32'(bus.out),       32'(vecs[i].exp_out));
      check($sformatf("v%0d_out_reg", i), 32'(bus.out_reg),   32'(prev_out));
      check($sformatf("v%0d_cnt", i),     32'(bus.match_cnt), 32'(vecs[i].exp_cnt));
      prev_out = vecs[i].exp_out;
    end

    // Saturation on the 2-bit counter: five non-overlapping 1011 groups.
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    grp = 4'b1011;
    pulses = 0;
    @(negedge clk);
    rst2 = 0;
    bus2.overlap = 0;
    for (int g = 0; g < 5; g++) begin
      for (int b = 3; b >= 0; b--) begin
        @(negedge clk);
        bus2.valid = 1;
        bus2.in    = grp[b];
        #1;
        if (bus2.out === 1'b1) pulses++;
        check($sformatf("sat_g%0d_b%0d_out", g, 3 - b), 32'(bus2.out),
              (b == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      bus2.valid = 0;
      #1;
      check($sformatf("sat_g%0d_cnt", g), 32'(bus2.match_cnt), 32'(sat_exp[g]));
      check($sformatf("sat_g%0d_out_reg", g), 32'(bus2.out_reg), 32'd1);
    end
    check("sat_pulses", 32'(pulses), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
